// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: state encoding and counter-width helper shared by the
// word serializer and its bit timer.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN (adds the PARITY state).
package word_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef WORD_SERIALIZER_PARITY_EN
      ,PARITY = 2'd2
`endif
   } state_t;

   // Counter width for a modulus of n: $clog2(n), never less than one bit.
   function automatic int unsigned ctr_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/word_serializer_bit_timer.sv
// bit_timer: CLKS_PER_BIT clock divider plus the bit-within-word counter.
// bit_done pulses in the last cycle of every bit period while run is high;
// last_bit flags that the current bit is bit WIDTH-1 of the word.
module bit_timer
   import word_serializer_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clear,
   input  logic run,
   output logic bit_done,
   output logic last_bit
);

   localparam int unsigned DW = ctr_width(CLKS_PER_BIT);
   localparam int unsigned BW = ctr_width(WIDTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;

   assign bit_done = run && (div_cnt == DIV_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   // Divider and bit counter; both return to zero at the end of each bit/word
   always_ff @(posedge i_clk) begin
      if (i_rst || clear) begin
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (run) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: accepts a WIDTH-bit word over valid/ready and shifts it out
// MSB-first, one bit per CLKS_PER_BIT cycles. o_ready rises in the final cycle
// of a frame so words can be streamed back-to-back.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN appends an even-parity bit.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_bit,
   output logic             o_bit_valid,
   output logic             o_frame_start,
   output logic             o_busy
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic             transfer;
   logic             bit_done;
   logic             last_bit;
   logic             timer_clear;
   logic             run;
   logic             frame_start_q;
`ifdef WORD_SERIALIZER_PARITY_EN
   logic             parity_q;
`endif

   // Ready is kept out of the FSM process so the transfer term never loops back
`ifdef WORD_SERIALIZER_PARITY_EN
   assign o_ready = (state == IDLE) || ((state == PARITY) && bit_done);
`else
   assign o_ready = (state == IDLE) || ((state == SHIFT) && bit_done && last_bit);
`endif

   assign transfer      = i_valid && o_ready && !i_rst;
   assign run           = (state != IDLE);
   assign o_frame_start = frame_start_q;

   bit_timer #(
      .WIDTH        (WIDTH),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .clear    (timer_clear),
      .run      (run),
      .bit_done (bit_done),
      .last_bit (last_bit)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and serial outputs
   always_comb begin
      state_nxt   = state;
      o_bit       = 1'b0;
      o_bit_valid = 1'b0;
      o_busy      = 1'b0;
      timer_clear = transfer;
      case (state)
         IDLE: begin
            if (transfer) state_nxt = SHIFT;
         end
         SHIFT: begin
            o_bit       = shreg[WIDTH-1];
            o_bit_valid = 1'b1;
            o_busy      = 1'b1;
            if (bit_done && last_bit) begin
`ifdef WORD_SERIALIZER_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = transfer ? SHIFT : IDLE;
`endif
            end
         end
`ifdef WORD_SERIALIZER_PARITY_EN
         PARITY: begin
            o_bit       = parity_q;
            o_bit_valid = 1'b1;
            o_busy      = 1'b1;
            if (bit_done) begin
               timer_clear = 1'b1;
               state_nxt   = transfer ? SHIFT : IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Shift register load/shift and frame-start flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shreg         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= transfer;
         if (transfer)
            shreg <= i_data;
         else if ((state == SHIFT) && bit_done)
            shreg <= {shreg[WIDTH-2:0], 1'b0};
      end
   end

`ifdef WORD_SERIALIZER_PARITY_EN
   // Even parity of the accepted word, captured at load time
   always_ff @(posedge i_clk) begin
      if (i_rst)         parity_q <= 1'b0;
      else if (transfer) parity_q <= ^i_data;
   end
`endif

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: two instances (CLKS_PER_BIT = 1 and 3) driven by
// independent sources and checked every cycle against a queue-of-bits model.
// Honours WORD_SERIALIZER_PARITY_EN when defined.
module tb_word_serializer;

   localparam int unsigned W = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif

   typedef struct packed {
      logic b;
      logic s;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [W-1:0] d0, d1;
   logic         v0, v1;
   logic         rdy0, bit0, bv0, fs0, busy0;
   logic         rdy1, bit1, bv1, fs1, busy1;

   word_serializer #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_data(d0), .i_valid(v0),
      .o_ready(rdy0), .o_bit(bit0), .o_bit_valid(bv0),
      .o_frame_start(fs0), .o_busy(busy0)
   );

   word_serializer #(.WIDTH(W), .CLKS_PER_BIT(3)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_data(d1), .i_valid(v1),
      .o_ready(rdy1), .o_bit(bit1), .o_bit_valid(bv1),
      .o_frame_start(fs1), .o_busy(busy1)
   );

   // Expected per-cycle output stream of each instance (front = current cycle)
   ent_t         q0[$];
   ent_t         q1[$];
   // Words waiting to be offered by each source
   logic [W-1:0] src0[$];
   logic [W-1:0] src1[$];

   int           checks = 0;
   int           errors = 0;
   int           cycle  = 0;
   bit           gaps   = 1'b0;
   logic [W-1:0] ds0;
   int           fs_cnt0, bv_cnt0, bv_cnt1;

   function automatic void push_frame(input int id, input logic [W-1:0] w);
      int unsigned cpb;
      ent_t        e;
      cpb = (id == 0) ? 1 : 3;
      for (int i = W - 1; i >= 0; i--)
         for (int unsigned r = 0; r < cpb; r++) begin
            e.b = w[i];
            e.s = (i == W - 1) && (r == 0);
            if (id == 0) q0.push_back(e); else q1.push_back(e);
         end
      if (PAR != 0)
         for (int unsigned r = 0; r < cpb; r++) begin
            e.b = ^w;
            e.s = 1'b0;
            if (id == 0) q0.push_back(e); else q1.push_back(e);
         end
   endfunction

   task automatic check_dut(input string tag, input int qsize, input ent_t front,
                            input logic [4:0] obs);
      logic [4:0] exp;
      if (qsize == 0) exp = 5'b10000;
      else            exp = {(qsize == 1), front.b, 1'b1, front.s, 1'b1};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d {rdy,bit,bv,fs,busy} obs=%b exp=%b", tag, cycle, obs, exp);
      end
   endtask

   task automatic step();
      logic a0, a1;
      @(negedge clk);
      check_dut("dut0", q0.size(), (q0.size() > 0) ? q0[0] : ent_t'(0),
                {rdy0, bit0, bv0, fs0, busy0});
      check_dut("dut1", q1.size(), (q1.size() > 0) ? q1[0] : ent_t'(0),
                {rdy1, bit1, bv1, fs1, busy1});
      if (bv0 === 1'b1) ds0 = {ds0[W-2:0], bit0};
      fs_cnt0 += (fs0 === 1'b1) ? 1 : 0;
      bv_cnt0 += (bv0 === 1'b1) ? 1 : 0;
      bv_cnt1 += (bv1 === 1'b1) ? 1 : 0;
      a0 = v0 && (q0.size() <= 1) && !rst;
      a1 = v1 && (q1.size() <= 1) && !rst;
      @(posedge clk);
      cycle++;
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (a0) begin push_frame(0, d0); void'(src0.pop_front()); end
         if (a1) begin push_frame(1, d1); void'(src1.pop_front()); end
      end
      #1;
      if (!(v0 && !a0)) v0 = (src0.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      if (!(v1 && !a1)) v1 = (src1.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      d0 = v0 ? src0[0] : W'($urandom);
      d1 = v1 ? src1[0] : W'($urandom);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while ((q0.size() + q1.size() + src0.size() + src1.size() != 0 || v0 || v1)
             && n < max_cycles) begin
         step();
         n++;
      end
      repeat (2) step();
      checks++;
      assert (n < max_cycles) else begin
         errors++;
         $error("FAIL drain_timeout cycles=%0d limit=%0d", n, max_cycles);
      end
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] exp_ds;
      int           n;

      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ds0 = '0;
      fs_cnt0 = 0; bv_cnt0 = 0; bv_cnt1 = 0;
      @(posedge clk); #1;
      repeat (2) step();
      rst = 1'b0;

      // Single word: 0xA5 on the fast instance, 0x81 on the slow one
      fs_cnt0 = 0;
      src0.push_back(8'hA5);
      src1.push_back(8'h81);
      wait_idle(200);
      w = 8'hA5;
      if (PAR != 0) exp_ds = {w[W-2:0], ^w};
      else          exp_ds = w;
      checks++;
      assert (ds0 === exp_ds) else begin
         errors++;
         $error("FAIL downstream_word obs=%h exp=%h", ds0, exp_ds);
      end
      checks++;
      assert (fs_cnt0 == 1) else begin
         errors++;
         $error("FAIL frame_start_single obs=%0d exp=1", fs_cnt0);
      end

      // Back-to-back words with valid held high
      fs_cnt0 = 0; bv_cnt0 = 0;
      src0.push_back(8'h3C); src0.push_back(8'hC3);
      src1.push_back(8'h3C); src1.push_back(8'hC3);
      wait_idle(200);
      checks++;
      assert (bv_cnt0 == 2 * (W + PAR)) else begin
         errors++;
         $error("FAIL b2b_bit_count obs=%0d exp=%0d", bv_cnt0, 2 * (W + PAR));
      end
      checks++;
      assert (fs_cnt0 == 2) else begin
         errors++;
         $error("FAIL b2b_frame_starts obs=%0d exp=2", fs_cnt0);
      end

      // Backpressure: second word offered mid-frame
      src0.push_back(8'h96); src1.push_back(8'h96);
      repeat (4) step();
      src0.push_back(8'h55); src1.push_back(8'h55);
      wait_idle(200);

      // Parity-sensitive words (odd and even population)
      src0.push_back(8'h07); src0.push_back(8'h03);
      src1.push_back(8'h07); src1.push_back(8'h03);
      wait_idle(200);

      // Reset after four bits of 0xFF
      src0.push_back(8'hFF); src1.push_back(8'hFF);
      n = 0;
      while (q0.size() == 0 && n < 20) begin step(); n++; end
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bv_cnt0 = 0; bv_cnt1 = 0;
      repeat (12) step();
      checks++;
      assert (bv_cnt0 + bv_cnt1 == 0) else begin
         errors++;
         $error("FAIL bits_after_reset obs=%0d exp=0", bv_cnt0 + bv_cnt1);
      end

      // Random words with random source gaps
      gaps = 1'b1;
      for (int i = 0; i < 40; i++) begin
         src0.push_back(W'($urandom));
         src1.push_back(W'($urandom));
      end
      wait_idle(5000);

      // Random words streamed back-to-back
      gaps = 1'b0;
      for (int i = 0; i < 20; i++) begin
         src0.push_back(W'($urandom));
         src1.push_back(W'($urandom));
      end
      wait_idle(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
